// File: rtl/rv32_hart_sched.sv
// rv32_hart_sched
// Round-robin hart scheduler for the barrel RV32 core. Each hart has an
// architectural PC and a state (OFF / READY / ISSUED). One (hart, pc) pair is
// offered to fetch through a valid/ready slot. A hart has at most one
// instruction in flight and becomes eligible again only when writeback
// returns its next PC.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   hart_en       - per-hart run enable from the CSR unit
//   issue_valid   - issue slot holds a valid (hart, pc)
//   issue_ready   - fetch accepts the slot this cycle
//   issue_hart    - hart id in the slot
//   issue_pc      - PC in the slot
//   wb_valid      - writeback returns a next PC
//   wb_hart       - hart the returned PC belongs to
//   wb_pc         - next PC for wb_hart
//   hart_busy     - per-hart ISSUED flag (includes a hart waiting in the slot)
//   sched_err     - sticky flag: writeback for a hart that was not ISSUED
module rv32_hart_sched #(
    parameter int                 NUM_HARTS = 8,
    parameter int                 XPR_LEN   = 32,
    parameter logic [XPR_LEN-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_HARTS-1:0]         hart_en,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [$clog2(NUM_HARTS)-1:0] issue_hart,
    output logic [XPR_LEN-1:0]           issue_pc,
    input  logic                         wb_valid,
    input  logic [$clog2(NUM_HARTS)-1:0] wb_hart,
    input  logic [XPR_LEN-1:0]           wb_pc,
    output logic [NUM_HARTS-1:0]         hart_busy,
    output logic                         sched_err
);

    localparam int HW = $clog2(NUM_HARTS);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_READY  = 2'd1,
        S_ISSUED = 2'd2
    } hart_state_t;

    hart_state_t        state [NUM_HARTS];
    logic [XPR_LEN-1:0] pc    [NUM_HARTS];
    logic [HW-1:0]      rr_ptr;

    logic [HW-1:0]      cand;
    logic [HW-1:0]      win_hart;
    logic               win_found;
    logic               slot_free;
    logic               load;
    logic               wb_bad;

    // Round-robin search starting just after the last winner. NUM_HARTS is a
    // power of two, so the HW-bit add wraps modulo NUM_HARTS by itself; the
    // last candidate (i == NUM_HARTS) is rr_ptr itself.
    always_comb begin
        win_found = 1'b0;
        win_hart  = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_HARTS; i++) begin
            cand = rr_ptr + HW'(i);
            if (!win_found && (state[cand] == S_READY)) begin
                win_found = 1'b1;
                win_hart  = cand;
            end
        end
    end

    assign slot_free = !issue_valid || issue_ready;
    assign load      = slot_free && win_found;
    // A writeback is only legal for a hart with an instruction in flight.
    assign wb_bad    = wb_valid && (state[wb_hart] != S_ISSUED);

    // Per-hart state machines, PC registers and the issue slot. Selection
    // looks at the current state only, so a hart whose writeback lands this
    // cycle cannot win until the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                state[h] <= S_OFF;
                pc[h]    <= RESET_PC;
            end
            rr_ptr      <= HW'(NUM_HARTS - 1);
            issue_valid <= 1'b0;
            issue_hart  <= '0;
            issue_pc    <= '0;
            hart_busy   <= '0;
            sched_err   <= 1'b0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                case (state[h])
                    S_OFF: begin
                        if (hart_en[h]) begin
                            state[h] <= S_READY;
                        end
                    end
                    S_READY: begin
                        // Being loaded takes priority over a same-cycle
                        // disable: the selection already committed to it.
                        if (load && (win_hart == HW'(h))) begin
                            state[h]     <= S_ISSUED;
                            hart_busy[h] <= 1'b1;
                        end else if (!hart_en[h]) begin
                            state[h] <= S_OFF;
                        end
                    end
                    S_ISSUED: begin
                        // Disable never aborts an in-flight instruction; it
                        // only decides where the hart lands on writeback.
                        if (wb_valid && (wb_hart == HW'(h))) begin
                            pc[h]        <= wb_pc;
                            hart_busy[h] <= 1'b0;
                            state[h]     <= hart_en[h] ? S_READY : S_OFF;
                        end
                    end
                    default: begin
                        state[h]     <= S_OFF;
                        hart_busy[h] <= 1'b0;
                    end
                endcase
            end

            if (wb_bad) begin
                sched_err <= 1'b1;
            end

            // Slot holds its contents while valid and not accepted.
            if (slot_free) begin
                if (win_found) begin
                    issue_valid <= 1'b1;
                    issue_hart  <= win_hart;
                    issue_pc    <= pc[win_hart];
                    rr_ptr      <= win_hart;
                end else begin
                    issue_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_hart_sched.sv
// tb_rv32_hart_sched
// Self-checking bench for rv32_hart_sched (default parameters: 8 harts,
// 32-bit PC, RESET_PC = 0). Expected issues are pushed to a scoreboard queue
// when stimulus is set up and popped when the DUT presents them.
module tb_rv32_hart_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hart_en;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_hart;
    logic [31:0] issue_pc;
    logic        wb_valid;
    logic [2:0]  wb_hart;
    logic [31:0] wb_pc;
    logic [7:0]  hart_busy;
    logic        sched_err;

    typedef struct packed {
        logic [2:0]  hart;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [2:0]  hart;
        logic [31:0] pc;
        int          due;
    } wb_t;

    exp_t sb[$];
    wb_t  pend[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rv32_hart_sched dut (
        .clk         (clk),
        .rst         (rst),
        .hart_en     (hart_en),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_hart  (issue_hart),
        .issue_pc    (issue_pc),
        .wb_valid    (wb_valid),
        .wb_hart     (wb_hart),
        .wb_pc       (wb_pc),
        .hart_busy   (hart_busy),
        .sched_err   (sched_err)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs are changed here, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges with idle inputs, release just after an edge.
    task automatic do_reset();
        rst         = 1'b1;
        hart_en     = '0;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        wb_hart     = '0;
        wb_pc       = '0;
        sb.delete();
        pend.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Outputs must sit at reset values even with busy inputs during reset.
    task automatic test_reset();
        do_reset();
        rst         = 1'b1;
        hart_en     = 8'hFF;
        issue_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_hart     = 3'd2;
        wb_pc       = 32'h44;
        repeat (2) tick();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_issue_valid: got %b want 0", issue_valid);
        end
        n_checks++;
        if (issue_hart !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_issue_hart: got %0d want 0", issue_hart);
        end
        n_checks++;
        if (issue_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_issue_pc: got %h want 0", issue_pc);
        end
        n_checks++;
        if (hart_busy !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_hart_busy: got %h want 00", hart_busy);
        end
        n_checks++;
        if (sched_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_sched_err: got %b want 0", sched_err);
        end
        wb_valid = 1'b0;
    endtask

    // One enabled hart: single issue, slot empties, writeback re-arms it.
    task automatic test_single_hart();
        exp_t e;
        do_reset();
        hart_en     = 8'h01;
        issue_ready = 1'b1;
        sb.push_back(exp_t'{hart: 3'd0, pc: 32'h0});
        tick();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_early_valid: got %b want 0", issue_valid);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL single_first_issue: valid %b want 1", issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                n_fail++;
                $display("[TB] FAIL single_first_issue: got (%0d,%h) want (%0d,%h)",
                         issue_hart, issue_pc, e.hart, e.pc);
            end
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b0 || hart_busy !== 8'h01) begin
            n_fail++;
            $display("[TB] FAIL single_after_accept: valid %b busy %h want 0 / 01",
                     issue_valid, hart_busy);
        end
        wb_valid = 1'b1;
        wb_hart  = 3'd0;
        wb_pc    = 32'h4;
        sb.push_back(exp_t'{hart: 3'd0, pc: 32'h4});
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if (issue_valid !== 1'b0 || hart_busy !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL single_wb_no_bypass: valid %b busy %h want 0 / 00",
                     issue_valid, hart_busy);
        end
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL single_reissue: valid %b want 1", issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                n_fail++;
                $display("[TB] FAIL single_reissue: got (%0d,%h) want (%0d,%h)",
                         issue_hart, issue_pc, e.hart, e.pc);
            end
        end
        n_checks++;
        if (sched_err !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL single_end: err %b left %0d want 0 / 0", sched_err, sb.size());
        end
    endtask

    // All harts enabled, ready always high, writeback 4 cycles after accept:
    // three full rotations back to back with PCs 0, 4, 8.
    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        int   got;
        int   first_c;
        int   last_c;
        do_reset();
        hart_en     = 8'hFF;
        issue_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int h = 0; h < 8; h++) begin
                sb.push_back(exp_t'{hart: 3'(h), pc: 32'(4 * r)});
            end
        end
        cyc     = 0;
        got     = 0;
        first_c = -1;
        last_c  = -1;
        while (cyc < 80 && got < 24) begin
            tick();
            cyc++;
            wb_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                wb_valid = 1'b1;
                wb_hart  = pend[0].hart;
                wb_pc    = pend[0].pc;
                void'(pend.pop_front());
            end
            if (issue_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rr_unexpected: got (%0d,%h) with empty scoreboard",
                             issue_hart, issue_pc);
                end else begin
                    e = sb.pop_front();
                    if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                        n_fail++;
                        $display("[TB] FAIL rr_issue_%0d: got (%0d,%h) want (%0d,%h)",
                                 got, issue_hart, issue_pc, e.hart, e.pc);
                    end
                end
                pend.push_back(wb_t'{hart: issue_hart, pc: issue_pc + 32'd4, due: cyc + 4});
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
        end
        wb_valid = 1'b0;
        n_checks++;
        if (got != 24 || (last_c - first_c) != 23) begin
            n_fail++;
            $display("[TB] FAIL rr_no_gaps: issues %0d span %0d want 24 / 23",
                     got, last_c - first_c);
        end
        n_checks++;
        if (sched_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_sched_err: got %b want 0", sched_err);
        end
    endtask

    // Slot held for 5 cycles with ready low; then rotation continues at hart 1.
    task automatic test_stall();
        exp_t e;
        do_reset();
        hart_en     = 8'hFF;
        issue_ready = 1'b0;
        sb.push_back(exp_t'{hart: 3'd0, pc: 32'h0});
        sb.push_back(exp_t'{hart: 3'd1, pc: 32'h0});
        sb.push_back(exp_t'{hart: 3'd2, pc: 32'h0});
        repeat (2) tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (issue_valid !== 1'b1 || issue_hart !== 3'd0 || issue_pc !== 32'h0 ||
                hart_busy !== 8'h01) begin
                n_fail++;
                $display("[TB] FAIL stall_hold_%0d: got v%b (%0d,%h) busy %h want v1 (0,0) busy 01",
                         c, issue_valid, issue_hart, issue_pc, hart_busy);
            end
        end
        issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            n_checks++;
            if (issue_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL stall_resume_%0d: valid %b want 1", k, issue_valid);
            end else begin
                e = sb.pop_front();
                if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                    n_fail++;
                    $display("[TB] FAIL stall_resume_%0d: got (%0d,%h) want (%0d,%h)",
                             k, issue_hart, issue_pc, e.hart, e.pc);
                end
            end
        end
        n_checks++;
        if (hart_busy !== 8'h07) begin
            n_fail++;
            $display("[TB] FAIL stall_busy: got %h want 07", hart_busy);
        end
    endtask

    // Disable hart 3 while ISSUED: writeback parks it OFF, re-enable resumes
    // at the returned PC.
    task automatic test_disable_issued();
        exp_t e;
        int   seen;
        do_reset();
        hart_en     = 8'h08;
        issue_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_hart !== 3'd3 || issue_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL dis_first_issue: got v%b (%0d,%h) want v1 (3,0)",
                     issue_valid, issue_hart, issue_pc);
        end
        hart_en = 8'h00;
        tick();
        n_checks++;
        if (hart_busy !== 8'h08) begin
            n_fail++;
            $display("[TB] FAIL dis_still_busy: got %h want 08", hart_busy);
        end
        wb_valid = 1'b1;
        wb_hart  = 3'd3;
        wb_pc    = 32'h100;
        tick();
        wb_valid = 1'b0;
        seen     = 0;
        repeat (3) begin
            tick();
            if (issue_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || hart_busy !== 8'h00 || sched_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL dis_parked: issues %0d busy %h err %b want 0 / 00 / 0",
                     seen, hart_busy, sched_err);
        end
        hart_en = 8'h08;
        sb.push_back(exp_t'{hart: 3'd3, pc: 32'h100});
        tick();
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL dis_reenable: valid %b want 1", issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                n_fail++;
                $display("[TB] FAIL dis_reenable: got (%0d,%h) want (%0d,%h)",
                         issue_hart, issue_pc, e.hart, e.pc);
            end
        end
    endtask

    // Stray writeback sets the sticky error without touching the PC; a
    // mid-stream reset clears everything asynchronously and PCs restart.
    task automatic test_err_and_midreset();
        exp_t e;
        do_reset();
        hart_en     = 8'h00;
        issue_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_hart     = 3'd5;
        wb_pc       = 32'h200;
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if (sched_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_set: got %b want 1", sched_err);
        end
        hart_en = 8'h20;
        sb.push_back(exp_t'{hart: 3'd5, pc: 32'h0});
        repeat (2) tick();
        n_checks++;
        if (issue_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL err_pc_kept: valid %b want 1", issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                n_fail++;
                $display("[TB] FAIL err_pc_kept: got (%0d,%h) want (%0d,%h)",
                         issue_hart, issue_pc, e.hart, e.pc);
            end
        end
        tick();
        wb_valid = 1'b1;
        wb_hart  = 3'd5;
        wb_pc    = 32'h80;
        tick();
        wb_valid = 1'b0;
        tick();
        n_checks++;
        if (issue_valid !== 1'b1 || issue_hart !== 3'd5 || issue_pc !== 32'h80 ||
            sched_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_sticky_reissue: got v%b (%0d,%h) err %b want v1 (5,80) err 1",
                     issue_valid, issue_hart, issue_pc, sched_err);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (issue_valid !== 1'b0 || issue_hart !== 3'd0 || issue_pc !== 32'h0 ||
            hart_busy !== 8'h00 || sched_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_async: got v%b (%0d,%h) busy %h err %b want all zero",
                     issue_valid, issue_hart, issue_pc, hart_busy, sched_err);
        end
        rst = 1'b0;
        sb.push_back(exp_t'{hart: 3'd5, pc: 32'h0});
        repeat (2) tick();
        n_checks++;
        if (issue_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart: valid %b want 1", issue_valid);
        end else begin
            e = sb.pop_front();
            if (issue_hart !== e.hart || issue_pc !== e.pc) begin
                n_fail++;
                $display("[TB] FAIL midreset_restart: got (%0d,%h) want (%0d,%h)",
                         issue_hart, issue_pc, e.hart, e.pc);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        hart_en     = '0;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        wb_hart     = '0;
        wb_pc       = '0;
        $display("[TB] rv32_hart_sched bench start");
        test_reset();
        test_single_hart();
        test_back_to_back();
        test_stall();
        test_disable_issued();
        test_err_and_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_hart_sched.md
# rv32_hart_sched

Round-robin hart scheduler for the barrel RV32 core: holds one architectural PC per hart and hands the fetch stage one `(hart, pc)` pair per accepted handshake. It enforces at most one instruction in flight per hart. A hart becomes eligible again only when writeback returns its next PC. The block sits between writeback (PC return) and fetch (issue), and takes its enable mask from the CSR unit.

## Interface

Parameters:

- `NUM_HARTS`, default 8: number of harts; power of two, ≥ 2.
- `XPR_LEN`, default 32: PC width.
- `RESET_PC`, default 32'h0: PC loaded into every hart on reset.

Ports (`HW = $clog2(NUM_HARTS)`):

- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `hart_en`, in, `NUM_HARTS`: per-hart run enable (from CSR).
- `issue_valid`, out, 1: issue slot holds a valid `(hart, pc)`.
- `issue_ready`, in, 1: fetch accepts the slot this cycle.
- `issue_hart`, out, HW: hart id of the slot.
- `issue_pc`, out, `XPR_LEN`: PC of the slot.
- `wb_valid`, in, 1: writeback returns a next PC.
- `wb_hart`, in, HW: hart the returned PC belongs to.
- `wb_pc`, in, `XPR_LEN`: next PC for `wb_hart`.
- `hart_busy`, out, `NUM_HARTS`: hart in ISSUED state.
- `sched_err`, out, 1: sticky protocol-error flag.

## Operation

- Per-hart state is one of OFF, READY or ISSUED. Each hart also has a `pc[h]` register.
- Reset values:
  - all states OFF, all `pc[h] = RESET_PC`;
  - `rr_ptr = NUM_HARTS-1`, so hart 0 is searched first;
  - `issue_valid = 0`, `issue_hart = 0`, `issue_pc = 0`;
  - `hart_busy = 0`, `sched_err = 0`.
- Transitions, evaluated per hart each cycle:
  - OFF → READY when `hart_en[h] = 1`. The PC is retained, so re-enable resumes at the stored PC.
  - READY → OFF when `hart_en[h] = 0`.
  - READY → ISSUED when the hart is loaded into the issue slot.
  - ISSUED → READY when `wb_valid && wb_hart == h`. `pc[h]` is loaded from `wb_pc`.
  - ISSUED → OFF instead of READY if `hart_en[h] = 0` at that writeback. `pc[h]` is still updated.
  - Disable never aborts an issued instruction.
- Selection: combinational search over READY harts, starting at `rr_ptr+1` and wrapping modulo `NUM_HARTS`. The first READY hart found wins.
- Issue slot load:
  - The slot loads when it is free, i.e. `!issue_valid || issue_ready`, and a winner exists.
  - On load: `issue_valid ← 1`, `issue_hart ← winner`, `issue_pc ← pc[winner]`, `rr_ptr ← winner`, and the winner goes ISSUED.
  - If the slot is free and no hart is READY: `issue_valid ← 0`.
- Handshake rules:
  - While `issue_valid && !issue_ready`, `issue_hart` and `issue_pc` are held stable.
  - `hart_en` changes do not affect the occupied slot.
- Protocol errors: `wb_valid` for a hart not in ISSUED sets `sched_err`, which stays set until reset. That writeback is ignored: no PC or state change.
- `hart_busy[h] = 1` exactly when state is ISSUED. This includes a hart sitting in the slot and not yet accepted.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- Writeback → eligibility: `wb_valid` sampled at edge t makes the hart READY after t. The hart can appear on the issue slot after edge t+1, one cycle of latency.
- Enable → first issue: `hart_en[h]` rising, sampled at edge t, gives READY after t. Earliest `issue_valid` for that hart is after edge t+1.
- Throughput: one issue per cycle while `issue_ready = 1` and ≥ 1 READY hart exists each cycle.
- A single hart alone sustains one issue every 3+ cycles: issue, downstream latency, writeback, then re-select.
- Simultaneous events:
  - Writeback for hart h in the same cycle as selection: h is not eligible that cycle (no bypass).
  - Writeback and slot accept of different harts in the same cycle: both are processed.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously). In-flight writebacks arriving after reset release are protocol errors.

## Test plan

- Reset, `hart_en = 8'h01`, `issue_ready = 1`, no writeback → one issue `(0, 0x0)`, then `issue_valid = 0`. `hart_busy = 8'h01`.
- Follow-up: writeback hart 0 with PC 0x4 → next issue `(0, 0x4)` one cycle after the writeback edge.
- `hart_en = 8'hFF`, `issue_ready` held 1, each hart's writeback returned 4 cycles after its issue → issue order is 0,1,…,7,0,… with no gaps. Each hart's PCs advance 0x0, 0x4, 0x8.
- Stall: `issue_valid` high, `issue_ready = 0` for 5 cycles → hart and PC stable all 5 cycles. Round-robin resumes at the next hart after accept.
- Disable hart 3 while it is ISSUED, then writeback 3 with PC 0x100 → hart 3 goes OFF and is not issued. Re-enable → next issue is `(3, 0x100)`.
- Writeback for an OFF hart → `sched_err = 1` and stays set, with no PC change. Reset asserted mid-stream → `issue_valid = 0` immediately, and all harts restart at `RESET_PC`.
